// File: rtl/button_event_encoder.sv
// Button event encoder: turns the debounced button level into short / long /
// double press events and hands each one out as an ASCII byte over a
// single-entry valid/ready register feeding the UART TX byte port.
module button_event_encoder #(
    parameter logic [15:0] LONG_TICKS = 16'd1024,
    parameter logic [15:0] DOUBLE_GAP = 16'd307
) (
    input  logic       clk_1024,
    input  logic       reset,
    input  logic       enable,
    input  logic       prell_flag,
    input  logic       event_ready,
    output logic       event_valid,
    output logic [7:0] event_data,
    output logic [7:0] event_count,
    output logic       overrun
);

    localparam logic [7:0] CODE_SHORT  = 8'h53;  // 'S'
    localparam logic [7:0] CODE_LONG   = 8'h4C;  // 'L'
    localparam logic [7:0] CODE_DOUBLE = 8'h44;  // 'D'

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS1,
        S_LONG,
        S_GAP,
        S_PRESS2
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic        emit;
    logic [7:0]  emit_code;

    logic        valid_q;
    logic [7:0]  data_q;
    logic [7:0]  count_q;
    logic        overrun_q;
    logic        xfer;
    logic        store;

    // Classifier next state and event emission.
    always_comb begin
        state_d   = state_q;
        emit      = 1'b0;
        emit_code = 8'h00;
        if (!enable) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (prell_flag) state_d = S_PRESS1;
                end
                S_PRESS1: begin
                    // A release on the long-press boundary edge still counts
                    // as a short press.
                    if (!prell_flag) begin
                        state_d = S_GAP;
                    end else if (timer_q == LONG_TICKS - 16'd1) begin
                        emit      = 1'b1;
                        emit_code = CODE_LONG;
                        state_d   = S_LONG;
                    end
                end
                S_LONG: begin
                    if (!prell_flag) state_d = S_IDLE;
                end
                S_GAP: begin
                    // The gap timeout wins over a re-press sampled on the same
                    // edge: that press is too late and starts a new sequence.
                    if (timer_q == DOUBLE_GAP - 16'd1) begin
                        emit      = 1'b1;
                        emit_code = CODE_SHORT;
                        state_d   = S_IDLE;
                    end else if (prell_flag) begin
                        state_d = S_PRESS2;
                    end
                end
                S_PRESS2: begin
                    if (!prell_flag) begin
                        emit      = 1'b1;
                        emit_code = CODE_DOUBLE;
                        state_d   = S_IDLE;
                    end else if (timer_q == LONG_TICKS - 16'd1) begin
                        emit      = 1'b1;
                        emit_code = CODE_DOUBLE;
                        state_d   = S_LONG;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Timer restarts on each state entry and only runs in the timed states.
    always_comb begin
        timer_d = 16'd0;
        if (enable && (state_d == state_q) &&
            ((state_q == S_PRESS1) || (state_q == S_GAP) || (state_q == S_PRESS2)))
            timer_d = timer_q + 16'd1;
    end

    // Classifier state and timer registers.
    always_ff @(posedge clk_1024 or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            timer_q <= 16'd0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    assign xfer  = valid_q && event_ready;
    assign store = emit && (!valid_q || xfer);

    // Single-entry output register; an emit into a full, stalled slot is lost.
    always_ff @(posedge clk_1024 or posedge reset) begin
        if (reset) begin
            valid_q   <= 1'b0;
            data_q    <= 8'h00;
            count_q   <= 8'd0;
            overrun_q <= 1'b0;
        end else begin
            if (store) begin
                valid_q <= 1'b1;
                data_q  <= emit_code;
                count_q <= count_q + 8'd1;
            end else if (xfer) begin
                valid_q <= 1'b0;
            end
            if (emit && !store) overrun_q <= 1'b1;
        end
    end

    assign event_valid = valid_q;
    assign event_data  = data_q;
    assign event_count = count_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_button_event_encoder.sv
// Bench for button_event_encoder: scenario table, directed corner sequences
// and a randomized run against a timestamp-based reference model.
module tb_button_event_encoder;

    localparam int L  = 1024;
    localparam int DG = 307;

    logic       clk_1024 = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b1;
    logic       prell_flag = 1'b0;
    logic       event_ready = 1'b0;
    logic       event_valid;
    logic [7:0] event_data;
    logic [7:0] event_count;
    logic       overrun;

    int n_tests = 0;
    int n_fail  = 0;

    button_event_encoder #(.LONG_TICKS(16'd1024), .DOUBLE_GAP(16'd307)) dut (
        .clk_1024   (clk_1024),
        .reset      (reset),
        .enable     (enable),
        .prell_flag (prell_flag),
        .event_ready(event_ready),
        .event_valid(event_valid),
        .event_data (event_data),
        .event_count(event_count),
        .overrun    (overrun)
    );

    always #5 clk_1024 = ~clk_1024;

    typedef struct {
        int         p1;
        int         gap;
        int         p2;
        logic [7:0] code;
        int         at_edge;
    } vec_t;

    vec_t tbl[9];

    // Reference model state: timestamps of press / release edges.
    int         n_edge;
    int         mk, mr, mk2;
    bit         mlat;
    bit         mv, mo;
    logic [7:0] md, mc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_1024);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    // Press for len edges, then released, for total edges; reports first valid.
    task automatic run_press(input int len, input int total, output int first,
                             output logic [7:0] d, output int nval);
        first = -1;
        d     = 8'h00;
        nval  = 0;
        for (int e = 0; e < total; e++) begin
            prell_flag = (e < len);
            tick();
            if (event_valid) begin
                nval++;
                if (first < 0) begin
                    first = e;
                    d     = event_data;
                end
            end
        end
        prell_flag = 1'b0;
    endtask

    task automatic model_reset();
        n_edge = 0;
        mk = -1; mr = -1; mk2 = -1; mlat = 0;
        mv = 0; mo = 0; md = 8'h00; mc = 8'd0;
    endtask

    task automatic model_edge(input bit p, input bit en, input bit rdy);
        bit         em;
        logic [7:0] code;
        bit         xf;
        em   = 0;
        code = 8'h00;
        if (!en) begin
            mk = -1; mr = -1; mk2 = -1; mlat = 0;
        end else if (mlat) begin
            if (!p) mlat = 0;
        end else if (mk < 0) begin
            if (p) mk = n_edge;
        end else if (mr < 0) begin
            if (!p) mr = n_edge;
            else if (n_edge - mk == L) begin
                em = 1; code = "L"; mlat = 1; mk = -1;
            end
        end else if (mk2 < 0) begin
            if (n_edge - mr == DG) begin
                em = 1; code = "S"; mk = -1; mr = -1;
            end else if (p) mk2 = n_edge;
        end else begin
            if (!p) begin
                em = 1; code = "D"; mk = -1; mr = -1; mk2 = -1;
            end else if (n_edge - mk2 == L) begin
                em = 1; code = "D"; mk = -1; mr = -1; mk2 = -1; mlat = 1;
            end
        end
        xf = mv && rdy;
        if (em && (!mv || xf)) begin
            mv = 1; md = code; mc = mc + 8'd1;
        end else if (em) begin
            mo = 1;
        end else if (xf) begin
            mv = 0;
        end
        n_edge++;
    endtask

    initial begin
        int         first, nval, len, run;
        logic [7:0] d;
        logic [7:0] exp_cnt;
        bit         early, seen_v, lvl;
        logic [7:0] seen_d;

        tbl[0] = '{100,  0,   0,    8'h53, 407};
        tbl[1] = '{1023, 0,   0,    8'h53, 1330};
        tbl[2] = '{1024, 0,   0,    8'h53, 1331};
        tbl[3] = '{1025, 0,   0,    8'h4C, 1024};
        tbl[4] = '{50,   100, 50,   8'h44, 200};
        tbl[5] = '{5,    1,   3,    8'h44, 9};
        tbl[6] = '{10,   306, 5,    8'h44, 321};
        tbl[7] = '{10,   307, 5,    8'h53, 317};
        tbl[8] = '{10,   20,  2000, 8'h44, 1054};

        // Reset values.
        tick();
        do_reset();
        #1;
        chk("rst_valid", event_valid, 0);
        chk("rst_data", event_data, 8'h00);
        chk("rst_count", event_count, 0);
        chk("rst_overrun", overrun, 0);
        exp_cnt = 8'd0;

        // Scenario table, consumer stalled so the first event is held.
        for (int i = 0; i < 9; i++) begin
            run = ((tbl[i].at_edge > tbl[i].p1 + tbl[i].gap + tbl[i].p2) ?
                   tbl[i].at_edge : tbl[i].p1 + tbl[i].gap + tbl[i].p2) + 3;
            early  = 0;
            seen_v = 0;
            seen_d = 8'h00;
            event_ready = 1'b0;
            for (int e = 0; e < run; e++) begin
                prell_flag = (e < tbl[i].p1) ? 1'b1 :
                             (e < tbl[i].p1 + tbl[i].gap) ? 1'b0 :
                             (e < tbl[i].p1 + tbl[i].gap + tbl[i].p2) ? 1'b1 : 1'b0;
                tick();
                if (e < tbl[i].at_edge && event_valid) early = 1;
                if (e == tbl[i].at_edge) begin
                    seen_v = event_valid;
                    seen_d = event_data;
                end
            end
            exp_cnt = exp_cnt + 8'd1;
            chk($sformatf("tbl%0d_early", i), early, 0);
            chk($sformatf("tbl%0d_valid", i), seen_v, 1);
            chk($sformatf("tbl%0d_code", i), seen_d, tbl[i].code);
            chk($sformatf("tbl%0d_count", i), event_count, exp_cnt);
            chk($sformatf("tbl%0d_overrun", i), overrun, 0);
            prell_flag  = 1'b0;
            event_ready = 1'b1;
            enable      = 1'b0;
            tick();
            event_ready = 1'b0;
            enable      = 1'b1;
            tick();
            chk($sformatf("tbl%0d_drain", i), event_valid, 0);
        end

        // Long hold with a ready consumer: exactly one 'L', then back to idle.
        event_ready = 1'b1;
        run_press(2000, 2005, first, d, nval);
        exp_cnt = exp_cnt + 8'd1;
        chk("long_edge", first, L);
        chk("long_code", d, 8'h4C);
        chk("long_single", nval, 1);
        run_press(5, 320, first, d, nval);
        exp_cnt = exp_cnt + 8'd1;
        chk("after_long_edge", first, 5 + DG);
        chk("after_long_code", d, 8'h53);
        chk("after_long_count", event_count, exp_cnt);

        // Stalled consumer: second short press overruns.
        event_ready = 1'b0;
        run_press(5, 320, first, d, nval);
        exp_cnt = exp_cnt + 8'd1;
        chk("ovr_first_code", d, 8'h53);
        chk("ovr_first_flag", overrun, 0);
        run_press(5, 320, first, d, nval);
        chk("ovr_flag", overrun, 1);
        chk("ovr_held_valid", event_valid, 1);
        chk("ovr_held_data", event_data, 8'h53);
        chk("ovr_count", event_count, exp_cnt);
        event_ready = 1'b1;
        tick();
        chk("xfer_valid", event_valid, 0);
        chk("xfer_data_kept", event_data, 8'h53);
        event_ready = 1'b0;

        // Enable dropped mid-press abandons the press.
        run_press(501, 501, first, d, nval);
        prell_flag = 1'b1;
        enable = 1'b0;
        tick();
        prell_flag = 1'b0;
        enable = 1'b1;
        run_press(0, 1500, first, d, nval);
        chk("en_no_event", nval, 0);
        chk("en_count", event_count, exp_cnt);
        run_press(1030, 1035, first, d, nval);
        exp_cnt = exp_cnt + 8'd1;
        chk("en_next_edge", first, L);
        chk("en_next_code", d, 8'h4C);
        event_ready = 1'b1;
        enable = 1'b0;
        tick();
        chk("en_low_handshake", event_valid, 0);
        enable = 1'b1;
        event_ready = 1'b0;
        tick();

        // 256 accepted double presses wrap the counter.
        do_reset();
        event_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            for (int j = 0; j < 5; j++) begin
                prell_flag = (j == 0 || j == 2);
                tick();
            end
            if (i == 254) chk("wrap_255", event_count, 8'd255);
        end
        chk("wrap_0", event_count, 8'd0);
        chk("wrap_valid", event_valid, 0);
        event_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin
            prell_flag = (j == 0 || j == 2);
            tick();
        end
        chk("pre_rst_valid", event_valid, 1);
        chk("pre_rst_data", event_data, 8'h44);
        chk("pre_rst_count", event_count, 8'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst", {event_valid, event_data, event_count, overrun}, 18'd0);
        reset = 1'b0;
        prell_flag = 1'b0;

        // Randomized run against the reference model.
        tick();
        do_reset();
        model_reset();
        lvl = 1'b1;
        for (int s = 0; s < 150; s++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: len = $urandom_range(1, 6);
                6:                len = $urandom_range(DG - 2, DG + 1);
                7:                len = $urandom_range(L - 2, L + 1);
                8:                len = $urandom_range(10, 100);
                default:          len = $urandom_range(1, 3);
            endcase
            for (int j = 0; j < len; j++) begin
                prell_flag  = lvl;
                event_ready = ($urandom_range(0, 3) != 0);
                enable      = ($urandom_range(0, 299) != 0);
                model_edge(prell_flag, enable, event_ready);
                tick();
                chk("rand", {event_valid, event_data, event_count, overrun},
                    {mv, md, mc, mo});
            end
            lvl = ~lvl;
        end
        enable = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
